uart_tx_fifo: RTL
=================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Parameters
REQ-001 CLK_HZ, default 64_000_000, system clock frequency.
REQ-002 BIT_RATE, default 4_000_000, serial bit rate.
REQ-003 DEPTH, default 4, FIFO entries; power of two, 2..8.
REQ-004 CPB = CLK_HZ/BIT_RATE, integer division (16 at defaults); shall be >= 2, else elaboration error.

Interface
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 resetn  in  1  asynchronous, active-low reset; no other clock or reset exists.
REQ-007 wr_en  in  1  one-cycle byte write strobe from the bus decode (debug UART data address).
REQ-008 wr_data  in  8  byte to queue; sampled when wr_en=1.
REQ-009 uart_txd  out  1  8N1 serial output, idle high.
REQ-010 fifo_full  out  1  level == DEPTH.
REQ-011 fifo_empty  out  1  level == 0.
REQ-012 level  out  4  queued bytes, 0..DEPTH, excludes the byte being shifted.
REQ-013 tx_busy  out  1  high when FIFO non-empty or serializer not IDLE; read as the status register bit.
REQ-014 tx_done  out  1  one-cycle pulse at the end of each stop bit.

Function
REQ-015 FIFO: circular buffer, read/write pointers wrap modulo DEPTH; level is a registered counter.
REQ-016 Write accepted when wr_en=1 and fifo_full=0 at that edge; a write while full is silently dropped, with no state change.
REQ-017 A write and a pop on the same edge: both occur, level unchanged; at full, the write is still dropped (fifo_full is pre-edge).
REQ-018 Serializer states: IDLE, START, DATA, STOP; bit counter 0..7; divider counter 0..CPB-1.
REQ-019 IDLE: uart_txd=1; if fifo_empty=0, pop the head into the shift register and enter START, with the divider cleared.
REQ-020 START: uart_txd=0 for exactly CPB cycles, then DATA with bit index 0.
REQ-021 DATA: uart_txd = shift bit, LSB first, each held exactly CPB cycles; after bit 7 enter STOP.
REQ-022 STOP: uart_txd=1 for CPB cycles; on its last cycle assert tx_done. If fifo_empty=0, pop and go directly to START (no idle gap); otherwise go to IDLE.
REQ-023 Frame length: exactly 10*CPB cycles; back-to-back frames are contiguous.
REQ-024 Latency: a write at edge N to an empty FIFO with IDLE serializer gives level=1 after N, a pop at N+1, uart_txd=0 after N+1.
REQ-025 uart_txd is driven directly from a register, glitch-free.
REQ-026 tx_busy and the flags are combinational from registered state only, with no path from wr_en.

Reset
REQ-027 With resetn=0, asynchronously: state=IDLE, uart_txd=1, level=0, pointers=0, fifo_empty=1, fifo_full=0, tx_busy=0, tx_done=0, counters=0.
REQ-028 Reset mid-frame aborts the frame immediately (line goes high) and discards all queued bytes; FIFO storage contents need not be cleared.
REQ-029 The first edge after resetn rises behaves as IDLE with an empty FIFO; wr_en on that edge is accepted.

Verification
REQ-030 Single byte: write 0x55 at defaults -> txd low 16 cycles, then 1,0,1,0,1,0,1,0 at 16 cycles each, high 16; one tx_done at cycle 160 after the start; tx_busy falls with it.
REQ-031 Overflow: 6 writes 0x01..0x06 on consecutive cycles at defaults -> 0x01 popped on the second edge, 0x02..0x05 queued, 0x06 dropped; 5 frames output contiguous over 800 cycles, 5 tx_done pulses.
REQ-032 Flags: level walks 0,1,2,3,4 on writes; fifo_full=1 at 4; level decrements on each pop; fifo_empty=1 only at 0.
REQ-033 Simultaneous write and pop at level 2 (STOP last cycle) -> level stays 2, and byte order is preserved across pointer wrap (8+ bytes streamed, output order equals input order).
REQ-034 Reset mid-DATA (bit 3 of 0xA5) with 2 bytes queued -> txd=1 at once, level=0, tx_busy=0; a new write of 0x3C then transmits correctly.
REQ-035 CPB=2 build (CLK_HZ=8, BIT_RATE=4) -> 20-cycle frame, with timing per REQ-020..REQ-023.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Debug UART transmitter: a small byte FIFO that feeds an 8N1 serializer.
// Back-to-back frames are contiguous, and the serial line comes straight from a flop.
module uart_tx_fifo #(
   parameter int CLK_HZ   = 64_000_000,
   parameter int BIT_RATE = 4_000_000,
   parameter int DEPTH    = 4
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   output logic       uart_txd,
   output logic       fifo_full,
   output logic       fifo_empty,
   output logic [3:0] level,
   output logic       tx_busy,
   output logic       tx_done,
   output logic [1:0] tx_state
);

   localparam int CPB   = CLK_HZ / BIT_RATE;
   localparam int CNT_W = (CPB >= 2) ? $clog2(CPB) : 1;
   localparam int PTR_W = (DEPTH >= 2) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CPB - 1);

   generate
      if (CPB < 2) begin : g_bad_cpb
         $error("uart_tx_fifo: CLK_HZ/BIT_RATE must be at least 2");
      end
      if (DEPTH < 2 || DEPTH > 8 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
         $error("uart_tx_fifo: DEPTH must be a power of two in 2..8");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   // Write side: wr_en is a one-cycle strobe with no ready. The writer polls
   // fifo_full; a strobe that arrives while full is dropped without effect.
   logic [7:0]       mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr, wr_ptr;
   logic [3:0]       level_q;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] div_q, div_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shreg_q, shreg_d;
   logic             txd_q, txd_d;
   logic             pop, push, div_end;

   assign fifo_empty = (level_q == 4'd0);
   assign fifo_full  = (level_q == 4'(DEPTH));
   assign level      = level_q;
   assign push       = wr_en && !fifo_full;
   assign div_end    = (div_q == DIV_LAST);
   assign tx_busy    = !fifo_empty || (state_q != S_IDLE);
   assign tx_done    = (state_q == S_STOP) && div_end;
   assign uart_txd   = txd_q;
   assign tx_state   = state_q;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         level_q <= 4'd0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   level_q <= level_q + 4'd1;
            2'b01:   level_q <= level_q - 4'd1;
            default: level_q <= level_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         div_q   <= '0;
         bit_q   <= 3'd0;
         shreg_q <= 8'd0;
         txd_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         txd_q   <= txd_d;
      end
   end

   // txd_d is the line level for the coming cycle, so the line flop never glitches.
   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      txd_d   = txd_q;
      pop     = 1'b0;
      case (state_q)
         S_IDLE: begin
            txd_d = 1'b1;
            if (!fifo_empty) begin
               pop     = 1'b1;
               shreg_d = mem[rd_ptr];
               state_d = S_START;
               div_d   = '0;
               txd_d   = 1'b0;
            end
         end
         S_START: begin
            if (div_end) begin
               state_d = S_DATA;
               bit_d   = 3'd0;
               div_d   = '0;
               txd_d   = shreg_q[0];
            end else begin
               div_d = div_q + CNT_W'(1);
            end
         end
         S_DATA: begin
            if (div_end) begin
               div_d = '0;
               if (bit_q == 3'd7) begin
                  state_d = S_STOP;
                  txd_d   = 1'b1;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shreg_d = shreg_q >> 1;
                  txd_d   = shreg_q[1];
               end
            end else begin
               div_d = div_q + CNT_W'(1);
            end
         end
         S_STOP: begin
            txd_d = 1'b1;
            if (div_end) begin
               div_d = '0;
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  shreg_d = mem[rd_ptr];
                  state_d = S_START;
                  txd_d   = 1'b0;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               div_d = div_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            div_d   = '0;
            txd_d   = 1'b1;
         end
      endcase
   end

endmodule
